// File: rtl/eth_update_mux.sv
// Purpose: capture per-channel parameter words and serialize pending ones onto one valid/ready bus.
// Latency: load at edge k -> pending after k; with a free slot, dout_vld with that word after k+1.
// Backpressure: dout/dout_ch/dout_vld hold while !dout_rdy; loads keep updating buf/pend (newest wins).
//
// Ports:
//   clk, res         clock, async active-high reset
//   ena_buf, din     per-channel load strobe and packed data (channel i at [i*WIDTH +: WIDTH])
//   clr_cnt          synchronous clear of coalesce_cnt
//   dout, dout_ch,
//   dout_vld, dout_rdy  output word, its channel index, valid/ready handshake
//   pending          per-channel pending flags
//   coalesce_cnt     saturating count of pending words overwritten before being sent
module eth_update_mux #(
    parameter int                 WIDTH    = 16,
    parameter int                 CHANNELS = 4,
    parameter int                 CH_W     = 2,
    parameter logic [WIDTH-1:0]   INIT     = '0,
    parameter int                 CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        res,
    input  logic [CHANNELS-1:0]         ena_buf,
    input  logic [CHANNELS*WIDTH-1:0]   din,
    input  logic                        clr_cnt,
    output logic [WIDTH-1:0]            dout,
    output logic [CH_W-1:0]             dout_ch,
    output logic                        dout_vld,
    input  logic                        dout_rdy,
    output logic [CHANNELS-1:0]         pending,
    output logic [CNT_W-1:0]            coalesce_cnt
);

    // Wide enough to hold the number of channels coalescing in one cycle.
    localparam int SW = $clog2(CHANNELS + 1);

    logic [WIDTH-1:0]    buf_q [CHANNELS];
    logic [CHANNELS-1:0] pend;
    logic [CH_W-1:0]     last_grant;

    logic                slot_free;
    logic                found;
    logic                grant_vld;
    logic [CH_W-1:0]     grant_ch;
    logic [CH_W-1:0]     cand;
    int                  idx;
    logic [SW-1:0]       n_coal;
    logic [CNT_W+SW-1:0] cnt_sum;
    logic [CNT_W-1:0]    cnt_next;

    assign pending = pend;

    always_comb begin
        slot_free = !dout_vld || dout_rdy;
        found     = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        cand      = '0;
        // Round-robin: scan last_grant+1 upward, wrapping at CHANNELS-1 (not 2**CH_W-1).
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            cand = CH_W'(idx);
            if (!found && pend[cand]) begin
                found    = 1'b1;
                grant_ch = cand;
            end
        end
        grant_vld = slot_free && found;

        // A reload of the channel being granted is a re-send, not a coalesce.
        n_coal = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ena_buf[i] && pend[i] && !(grant_vld && grant_ch == CH_W'(i)))
                n_coal = n_coal + SW'(1);
        end

        cnt_sum = {{SW{1'b0}}, coalesce_cnt} + {{CNT_W{1'b0}}, n_coal};
        if (cnt_sum > {{SW{1'b0}}, {CNT_W{1'b1}}})
            cnt_next = {CNT_W{1'b1}};
        else
            cnt_next = cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < CHANNELS; i++) buf_q[i] <= '0;
            pend         <= '0;
            last_grant   <= CH_W'(CHANNELS - 1);
            dout         <= INIT;
            dout_ch      <= '0;
            dout_vld     <= 1'b0;
            coalesce_cnt <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (ena_buf[i]) begin
                    buf_q[i] <= din[i*WIDTH +: WIDTH];
                    pend[i]  <= 1'b1;
                end else if (grant_vld && grant_ch == CH_W'(i)) begin
                    pend[i]  <= 1'b0;
                end
            end

            if (slot_free) begin
                if (grant_vld) begin
                    dout       <= buf_q[grant_ch];
                    dout_ch    <= grant_ch;
                    dout_vld   <= 1'b1;
                    last_grant <= grant_ch;
                end else begin
                    dout_vld   <= 1'b0;
                end
            end

            if (clr_cnt)
                coalesce_cnt <= '0;
            else
                coalesce_cnt <= cnt_next;
        end
    end

endmodule

// File: doc/eth_update_mux.md
# eth_update_mux

Multi-channel successor to the single-bus update synchronizer: captures up to CHANNELS independent parameter words (e.g. MAC control/status registers), each with its own load strobe. Pending words are serialized onto one output bus with a valid/ready handshake. A channel reloaded while pending is coalesced, keeping only the newest value. A channel reloaded in the cycle it is granted is re-sent with the newer value. Single clock domain; sits between register-file writers and a downstream consumer or CDC stage.

## Interface
- WIDTH, 16: data word width per channel.
- CHANNELS, 4: number of input channels, 2..16.
- CH_W, 2: width of channel index; must satisfy 2**CH_W >= CHANNELS.
- INIT, 0: reset value of dout (WIDTH bits).
- CNT_W, 8: width of coalesce counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- res  in  1  reset, asynchronous, active-high; clears all state immediately.
- ena_buf  in  CHANNELS  per-channel load strobe, one-cycle or level.
- din  in  CHANNELS*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
- clr_cnt  in  1  synchronous clear of coalesce_cnt.
- dout  out  WIDTH  output word.
- dout_ch  out  CH_W  channel index of dout.
- dout_vld  out  1  dout/dout_ch valid.
- dout_rdy  in  1  consumer accepts when dout_vld && dout_rdy.
- pending  out  CHANNELS  per-channel pending flags.
- coalesce_cnt  out  CNT_W  saturating count of overwritten pending words.

## Operation
- Per channel i: holding register buf[i] and flag pend[i].
- Load: ena_buf[i]=1 at an edge sets buf[i] <= din slice i and pend[i] <= 1.
- Coalesce: if pend[i] was already 1 and channel i is not granted this cycle, the old value is lost and coalesce_cnt increments. Several channels coalescing in one cycle add their count together. The counter saturates at all-ones and never wraps.
- clr_cnt wins over any increment in the same cycle.
- Output slot is free when !dout_vld, or when dout_vld && dout_rdy (accept).
- Grant: when the slot is free and any pend=1, pick channel g by round-robin, searching from last_grant+1 upward with wrap to 0.
- On grant: dout <= buf[g] (value before this edge), dout_ch <= g, dout_vld <= 1, last_grant <= g.
- pend[g] clears on grant unless ena_buf[g]=1 in the same cycle. In that case buf[g] takes the new value and pend[g] stays 1, so the new value is sent later. This does not count as a coalesce.
- If the slot is free and no pend is set, dout_vld <= 0. dout and dout_ch keep their last values.
- While dout_vld && !dout_rdy, dout, dout_ch and dout_vld are held stable, and new loads only update buf/pend.
- pending output = pend register.
- Channels at index >= CHANNELS do not exist. The round-robin search wraps at CHANNELS-1, not at 2**CH_W-1.

## Timing
- Reset values: dout=INIT, dout_ch=0, dout_vld=0, pending=0, coalesce_cnt=0, all buf=0, last_grant=CHANNELS-1, so channel 0 has first priority.
- Latency: strobe sampled at edge k gives pending[i]=1 after edge k. With the slot free, dout_vld=1 with that data after edge k+1.
- Throughput: one word per cycle with dout_rdy held high. A grant can load in the same edge as an accept.
- Fairness: with all channels continuously pending, grants rotate 0,1,..,CHANNELS-1,0,...
- Simultaneous load on channel i and grant of i: the old buf is output and the new value stays pending.
- Reset mid-transfer: everything returns to reset values asynchronously. In-flight and pending data are discarded, with no spurious dout_vld after release.
- Held ena_buf acts as a load every cycle: the channel keeps re-pending and coalescing while it is not granted.

## Test plan
- Reset/idle: assert res mid-run with dout_vld=1 and pending=4'b1010 -> outputs go to dout=INIT, vld=0, pending=0, cnt=0 immediately. No activity for 20 cycles after release.
- Single load: ena_buf=4'b0001 with ch0=16'h0004 at edge k, dout_rdy=1 -> pending[0]=1 after k; dout=16'h0004, dout_ch=0, vld=1 after k+1; vld=0 after k+2.
- Round-robin: load all 4 channels with 16'h0A00+i in one cycle, rdy=1 -> dout_ch sequence 0,1,2,3 on four consecutive cycles. A second full round, with last_grant=3, also starts at ch0.
- Backpressure and coalesce: rdy=0, send ch1 = 16'h00B0 then ch1 = 16'h004C, 16'h0021, one per cycle, while ch1 is pending but not granted -> dout held stable; coalesce_cnt=2. After rdy=1, the next ch1 word is 16'h0021.
- Grant/load collision: ch2 pending with 16'h0176. Load 16'h013B into ch2 in the grant cycle -> dout=16'h0176, pending[2] stays 1, next ch2 output is 16'h013B, cnt unchanged.
- Counter saturation and clear: CNT_W=2, force 5 coalesces -> cnt=3 and holds. clr_cnt together with a coalesce -> cnt=0.
